// File: rtl/fifo.sv
`default_nettype none
// ============================================================================
//  Module   : fifo
//  Purpose  : Synchronous first-word-fall-through FIFO. Width is DBITS and
//             depth is 2**ABITS. The head entry is always visible on dout.
//             Status flags decode the registered occupancy count.
//  Revision : 1.0  initial release
// ============================================================================
module fifo #(
   parameter int DBITS = 8,
   parameter int ABITS = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             wr,
   input  logic             rd,
   input  logic [DBITS-1:0] din,
   output logic [DBITS-1:0] dout,
   output logic             full,
   output logic             empty,
   output logic             almost_full,
   output logic             almost_empty
);

   localparam int               DEPTH      = 2 ** ABITS;
   localparam logic [ABITS:0]   c_DEPTH    = (ABITS+1)'(DEPTH);
   localparam logic [ABITS:0]   c_ONE      = (ABITS+1)'(1);
   localparam logic [ABITS:0]   c_DEPTH_M1 = c_DEPTH - c_ONE;
   localparam logic [ABITS-1:0] c_PTR_ONE  = ABITS'(1);

   // Storage is intentionally left unreset; only pointers and count are cleared.
   logic [DBITS-1:0] r_mem [DEPTH];
   logic [ABITS-1:0] r_wr_ptr;
   logic [ABITS-1:0] r_rd_ptr;
   logic [ABITS:0]   r_count;

   logic             w_push;
   logic             w_pop;

   // When full, a simultaneous pop frees the slot at wr_ptr (== rd_ptr), so
   // the push is still allowed.
   assign w_push = wr && (!full || rd);
   assign w_pop  = rd && !empty;

   // Advance pointers and track occupancy.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
         if (w_pop)  r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + c_ONE;
            2'b01:   r_count <= r_count - c_ONE;
            default: r_count <= r_count;
         endcase
      end
   end

   // Write the accepted entry into the slot addressed by the write pointer.
   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wr_ptr] <= din;
   end

   // Fall-through head and flag decodes come only from registered state.
   assign dout         = r_mem[r_rd_ptr];
   assign full         = (r_count == c_DEPTH);
   assign empty        = (r_count == '0);
   assign almost_full  = (r_count >= c_DEPTH_M1);
   assign almost_empty = (r_count <= c_ONE);

endmodule
`default_nettype wire

// File: tb/tb_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fifo
//  Purpose  : Self-checking bench for fifo (DBITS=26, ABITS=4) against a
//             queue-based reference model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_fifo;

   localparam int DBITS = 26;
   localparam int ABITS = 4;
   localparam int DEPTH = 16;

   logic             clk = 1'b0;
   logic             reset = 1'b0;
   logic             wr = 1'b0;
   logic             rd = 1'b0;
   logic [DBITS-1:0] din = '0;
   logic [DBITS-1:0] dout;
   logic             full, empty, almost_full, almost_empty;

   int checks = 0;
   int failures = 0;

   logic [DBITS-1:0] q[$];

   fifo #(.DBITS(DBITS), .ABITS(ABITS)) dut (
      .clk(clk), .reset(reset), .wr(wr), .rd(rd), .din(din), .dout(dout),
      .full(full), .empty(empty), .almost_full(almost_full),
      .almost_empty(almost_empty)
   );

   always #5 clk = ~clk;

   // {full, almost_full, empty, almost_empty} expected for an occupancy n.
   function automatic logic [3:0] exp_flags(input int n);
      return {n == DEPTH, n >= DEPTH-1, n == 0, n <= 1};
   endfunction

   // Advance one rising edge and apply the behavioural rules to the model.
   task automatic cycle();
      int n;
      bit pe, po;
      @(posedge clk);
      n  = q.size();
      pe = wr && (n < DEPTH || rd);
      po = rd && (n > 0);
      if (reset) q.delete();
      else begin
         if (po) void'(q.pop_front());
         if (pe) q.push_back(din);
      end
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      cycle(); cycle();
      reset = 1'b0;
      cycle();
      checks++;
      if ({full, almost_full, empty, almost_empty} !== 4'b0011) begin
         failures++;
         $display("FAIL reset_flags got=%b exp=%b", {full, almost_full, empty, almost_empty}, 4'b0011);
      end
      rd = 1'b1; cycle(); rd = 1'b0;
      checks++;
      if ({full, almost_full, empty, almost_empty} !== 4'b0011) begin
         failures++;
         $display("FAIL rd_on_empty_flags got=%b exp=%b", {full, almost_full, empty, almost_empty}, 4'b0011);
      end
   endtask

   task automatic test_fall_through();
      wr = 1'b1; din = 26'h0000008;
      cycle();
      wr = 1'b0;
      checks++;
      if (dout !== 26'h0000008) begin
         failures++;
         $display("FAIL fallthrough_dout got=%h exp=%h", dout, 26'h0000008);
      end
      checks++;
      if ({full, almost_full, empty, almost_empty} !== 4'b0001) begin
         failures++;
         $display("FAIL fallthrough_flags got=%b exp=%b", {full, almost_full, empty, almost_empty}, 4'b0001);
      end
      rd = 1'b1; cycle(); rd = 1'b0;
      checks++;
      if (empty !== 1'b1) begin
         failures++;
         $display("FAIL fallthrough_empty got=%b exp=1", empty);
      end
   endtask

   task automatic test_fill_drop();
      for (int i = 0; i < DEPTH; i++) begin
         wr = 1'b1; din = DBITS'(i);
         cycle();
         if (i == DEPTH-2) begin
            checks++;
            if (almost_full !== 1'b1 || full !== 1'b0) begin
               failures++;
               $display("FAIL fill15 af=%b full=%b exp af=1 full=0", almost_full, full);
            end
         end
      end
      wr = 1'b0;
      checks++;
      if (full !== 1'b1) begin
         failures++;
         $display("FAIL fill16_full got=%b exp=1", full);
      end
      wr = 1'b1; din = DBITS'(99);
      cycle();
      wr = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         checks++;
         if (dout !== DBITS'(i)) begin
            failures++;
            $display("FAIL drain_dout[%0d] got=%0d exp=%0d", i, dout, i);
         end
         rd = 1'b1; cycle();
      end
      rd = 1'b0;
      checks++;
      if (empty !== 1'b1) begin
         failures++;
         $display("FAIL drain_empty got=%b exp=1", empty);
      end
   endtask

   task automatic test_full_rw();
      logic [DBITS-1:0] exp_seq [DEPTH];
      for (int i = 0; i < DEPTH; i++) begin
         wr = 1'b1; din = DBITS'(i); cycle();
      end
      wr = 1'b1; rd = 1'b1; din = DBITS'(100);
      cycle();
      wr = 1'b0; rd = 1'b0;
      checks++;
      if (full !== 1'b1 || almost_full !== 1'b1) begin
         failures++;
         $display("FAIL full_rw_flags full=%b af=%b exp 1 1", full, almost_full);
      end
      for (int i = 0; i < DEPTH-1; i++) exp_seq[i] = DBITS'(i+1);
      exp_seq[DEPTH-1] = DBITS'(100);
      for (int i = 0; i < DEPTH; i++) begin
         checks++;
         if (dout !== exp_seq[i]) begin
            failures++;
            $display("FAIL full_rw_drain[%0d] got=%0d exp=%0d", i, dout, exp_seq[i]);
         end
         rd = 1'b1; cycle();
      end
      rd = 1'b0;
      checks++;
      if (empty !== 1'b1) begin
         failures++;
         $display("FAIL full_rw_empty got=%b exp=1", empty);
      end
   endtask

   task automatic test_wrap_stream();
      for (int i = 0; i < 40; i++) begin
         wr = 1'b1; din = DBITS'(8*i); rd = (i > 0);
         cycle();
         checks++;
         if (dout !== DBITS'(8*i) || {full, almost_full, empty, almost_empty} !== 4'b0001) begin
            failures++;
            $display("FAIL stream[%0d] dout=%0d exp=%0d flags=%b exp=0001", i, dout, 8*i,
                     {full, almost_full, empty, almost_empty});
         end
      end
      wr = 1'b0; rd = 1'b1; cycle(); rd = 1'b0;
      checks++;
      if (empty !== 1'b1) begin
         failures++;
         $display("FAIL stream_end_empty got=%b exp=1", empty);
      end
   endtask

   task automatic test_reset_mid();
      for (int i = 0; i < 5; i++) begin
         wr = 1'b1; din = DBITS'(50+i); cycle();
      end
      wr = 1'b0;
      #2 reset = 1'b1;
      #1;
      q.delete();
      checks++;
      if ({full, almost_full, empty, almost_empty} !== 4'b0011) begin
         failures++;
         $display("FAIL async_reset_flags got=%b exp=0011", {full, almost_full, empty, almost_empty});
      end
      cycle();
      reset = 1'b0;
      wr = 1'b1; din = DBITS'(7);
      cycle();
      wr = 1'b0;
      checks++;
      if (dout !== DBITS'(7) || empty !== 1'b0) begin
         failures++;
         $display("FAIL post_reset_push dout=%0d empty=%b exp 7 0", dout, empty);
      end
      rd = 1'b1; cycle(); rd = 1'b0;
   endtask

   task automatic test_random();
      for (int i = 0; i < 400; i++) begin
         wr  = ($urandom_range(0, 99) < 60);
         rd  = ($urandom_range(0, 99) < 50);
         din = DBITS'($urandom);
         cycle();
         checks++;
         if ({full, almost_full, empty, almost_empty} !== exp_flags(q.size())) begin
            failures++;
            $display("FAIL rand_flags[%0d] got=%b exp=%b", i, {full, almost_full, empty, almost_empty},
                     exp_flags(q.size()));
         end
         if (q.size() > 0) begin
            checks++;
            if (dout !== q[0]) begin
               failures++;
               $display("FAIL rand_dout[%0d] got=%h exp=%h", i, dout, q[0]);
            end
         end
      end
      wr = 1'b0; rd = 1'b0;
   endtask

   initial begin
      #1;
      test_reset();
      test_fall_through();
      test_fill_drop();
      test_full_rw();
      test_wrap_stream();
      test_reset_mid();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
